// File: rtl/memory_access_unit.sv
// memory_access_unit: initiator side of the word-wide data-memory port.
// Turns byte/halfword/word loads and stores into word accesses. Sub-word stores
// read the word, merge the new lane and write it back. Misaligned, illegal-size
// or out-of-range requests answer with resp_error and never reach memory.
// Optional feature: define MAU_LAST_WORD_BYPASS_EN to keep a one-entry
// last-word buffer; a load or sub-word store that hits it skips READ/MERGE.
//
// state    | meaning
// ST_IDLE  | ready for a request, memory port idle
// ST_READ  | word address driven for a read
// ST_MERGE | read data valid: finish load or build merged store word
// ST_WRITE | write strobe asserted with the full word
module memory_access_unit #(
    parameter int unsigned WORD_LIMIT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [29:0] mem_address,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_input,
    input  logic [31:0] mem_read_result
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_MERGE = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        req_err;
    logic        byp_hit;
    logic [31:0] byp_word;

    // Pick the addressed lane out of a word and sign/zero-extend it.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic sign, input logic [1:0] lane);
        logic [31:0] shifted;
        logic [31:0] result;
        case (size)
            SZ_BYTE: begin
                shifted = word >> {lane, 3'b000};
                result  = {{24{sign & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                shifted = word >> {lane[1], 4'b0000};
                result  = {{16{sign & shifted[15]}}, shifted[15:0]};
            end
            default: result = word;
        endcase
        return result;
    endfunction

    // Replace the addressed byte/halfword lane of a word with right-justified data.
    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic [31:0] data);
        logic [31:0] mask;
        logic [4:0]  sh;
        if (size == SZ_BYTE) begin
            sh   = {lane, 3'b000};
            mask = 32'h0000_00FF << sh;
        end else begin
            sh   = {lane[1], 4'b0000};
            mask = 32'h0000_FFFF << sh;
        end
        return (word & ~mask) | ((data << sh) & mask);
    endfunction

    // Request legality: size, alignment and word range.
    always_comb begin
        req_err = (req_size == 2'b11)
                | ((req_size == SZ_HALF) && req_address[0])
                | ((req_size == SZ_WORD) && (req_address[1:0] != 2'b00))
                | ({2'b00, req_address[31:2]} >= WORD_LIMIT);
    end

`ifdef MAU_LAST_WORD_BYPASS_EN
    logic        byp_valid_q, byp_valid_d;
    logic [29:0] byp_idx_q, byp_idx_d;
    logic [31:0] byp_data_q, byp_data_d;

    assign byp_hit  = byp_valid_q && (byp_idx_q == req_address[31:2]);
    assign byp_word = byp_data_q;

    // Track the last word seen on the memory port, by read or by write.
    always_comb begin
        byp_valid_d = byp_valid_q;
        byp_idx_d   = byp_idx_q;
        byp_data_d  = byp_data_q;
        if (state_q == ST_MERGE) begin
            byp_valid_d = 1'b1;
            byp_idx_d   = addr_q[31:2];
            byp_data_d  = mem_read_result;
        end else if (state_q == ST_WRITE) begin
            byp_valid_d = 1'b1;
            byp_idx_d   = addr_q[31:2];
            byp_data_d  = wbuf_q;
        end
    end

    // Buffer registers; the entry is invalidated by reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            byp_valid_q <= 1'b0;
            byp_idx_q   <= '0;
            byp_data_q  <= '0;
        end else begin
            byp_valid_q <= byp_valid_d;
            byp_idx_q   <= byp_idx_d;
            byp_data_q  <= byp_data_d;
        end
    end
`else
    assign byp_hit  = 1'b0;
    assign byp_word = 32'h0000_0000;
`endif

    // Access sequencing: accept, read, merge/extract, write, respond.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wbuf_d       = wbuf_q;
        resp_valid_d = 1'b0;
        resp_error_d = resp_error_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_address;
                    wdata_d  = req_wdata;
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        wbuf_d  = req_wdata;
                        state_d = ST_WRITE;
                    end else if (byp_hit && !req_write) begin
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b0;
                        resp_rdata_d = extract(byp_word, req_size, req_signed, req_address[1:0]);
                    end else if (byp_hit) begin
                        wbuf_d  = merge(byp_word, req_size, req_address[1:0], req_wdata);
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: state_d = ST_MERGE;
            ST_MERGE: begin
                if (write_q) begin
                    wbuf_d  = merge(mem_read_result, size_q, addr_q[1:0], wdata_q);
                    state_d = ST_WRITE;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = extract(mem_read_result, size_q, signed_q, addr_q[1:0]);
                    state_d      = ST_IDLE;
                end
            end
            ST_WRITE: begin
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = '0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and response registers; reset drops any in-flight access.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wbuf_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wbuf_q       <= wbuf_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready        = (state_q == ST_IDLE);
    assign resp_valid       = resp_valid_q;
    assign resp_error       = resp_error_q;
    assign resp_rdata       = resp_rdata_q;
    assign mem_address      = (state_q == ST_IDLE) ? 30'd0 : addr_q[31:2];
    assign mem_write_enable = (state_q == ST_WRITE);
    assign mem_write_input  = wbuf_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Testbench for memory_access_unit: bench-side word memory, a request-level
// reference model (shadow memory, lane arithmetic, per-kind latency) and one
// compare process that checks the DUT every cycle.
module tb_memory_access_unit;
    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic [29:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_input;
    logic [31:0] mem_read_result;

    memory_access_unit #(.WORD_LIMIT(1024)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_error(resp_error),
        .resp_rdata(resp_rdata), .mem_address(mem_address),
        .mem_write_enable(mem_write_enable), .mem_write_input(mem_write_input),
        .mem_read_result(mem_read_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory attached to the DUT
    bit [31:0] mem [1024];
    bit [31:0] mem_rd;
    always @(posedge clock) begin
        if (mem_write_enable) mem[mem_address[9:0]] <= mem_write_input;
        else                  mem_rd <= mem[mem_address[9:0]];
    end
    assign mem_read_result = mem_rd;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    // Reference model state
    int unsigned cycle = 0;
    bit [31:0]   ref_mem [1024];
    bit          pend = 0;
    int unsigned due = 0;
    logic        exp_err;
    logic        exp_we;
    logic [29:0] exp_idx;
    logic [31:0] exp_rd, exp_wd;
    logic [31:0] hold = 32'h0;
    bit          byp_v = 0;
    logic [29:0] byp_w = '0;

    // Cycle count and reset effect on the model
    always @(posedge clock) begin
        cycle++;
        if (!reset) begin
            pend  = 0;
            hold  = 32'h0;
            byp_v = 0;
        end
    end

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] lane);
        logic [7:0]  b [4];
        logic [15:0] h;
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        if (sz == 2'd0) return (sg && b[lane][7]) ? {24'hFFFFFF, b[lane]} : {24'h0, b[lane]};
        if (sz == 2'd1) begin
            h = lane[1] ? {b[3], b[2]} : {b[1], b[0]};
            return (sg && h[15]) ? {16'hFFFF, h} : {16'h0, h};
        end
        return w;
    endfunction

    function automatic logic [31:0] store_val(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic [31:0] d);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        if (sz == 2'd0) b[lane] = d[7:0];
        else if (sz == 2'd1) begin
            b[{lane[1], 1'b0}] = d[7:0];
            b[{lane[1], 1'b1}] = d[15:8];
        end else return d;
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // Compare process: every cycle after the first edge
    always @(negedge clock) begin
        bit idle;
        if (cycle > 0) begin
            if (pend && cycle == due) begin
                chk("resp_valid", {31'b0, resp_valid}, 32'd1);
                chk("resp_error", {31'b0, resp_error}, {31'b0, exp_err});
                hold = exp_rd;
                if (exp_we) ref_mem[exp_idx[9:0]] = exp_wd;
                pend = 0;
                idle = 1;
            end else begin
                chk("resp_valid", {31'b0, resp_valid}, 32'd0);
                idle = !pend;
            end
            chk("resp_rdata", resp_rdata, hold);
            chk("req_ready", {31'b0, req_ready}, {31'b0, idle});
            if (idle) begin
                chk("idle_we", {31'b0, mem_write_enable}, 32'd0);
                chk("idle_addr", {2'b0, mem_address}, 32'd0);
            end else begin
                chk("mem_address", {2'b0, mem_address}, {2'b0, exp_idx});
                chk("mem_we", {31'b0, mem_write_enable}, {31'b0, exp_we && (cycle + 1 == due)});
                if (exp_we && (cycle + 1 == due)) chk("mem_wdata", mem_write_input, exp_wd);
            end
        end
    end

    // Wait for the model's outstanding op to complete (call at negedge+1)
    task automatic wait_done();
        int g = 0;
        while (pend && g < 40) begin
            @(negedge clock); #1;
            g++;
        end
        chk("wait_done_timeout", {31'b0, pend}, 32'd0);
    endtask

    // Present one request; called at negedge+1, returns at negedge+1 after the accept edge
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        int unsigned lat;
        bit          hit;
        logic [31:0] cur;
        int g = 0;
        while (pend && g < 40) begin
            @(negedge clock); #1;
            g++;
        end
        if (pend) chk("issue_timeout", {31'b0, pend}, 32'd0);
        exp_idx = a[31:2];
        exp_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
                  || (a[31:2] >= 30'd1024);
        cur = ref_mem[a[11:2]];
`ifdef MAU_LAST_WORD_BYPASS_EN
        hit = byp_v && (byp_w == a[31:2]);
`else
        hit = 0;
`endif
        exp_we = 0;
        exp_rd = 32'h0;
        exp_wd = 32'h0;
        if (exp_err) lat = 0;
        else if (!w) begin
            exp_rd = load_val(cur, sz, sg, a[1:0]);
            lat = hit ? 0 : 2;
        end else begin
            exp_we = 1;
            exp_wd = store_val(cur, sz, a[1:0], wd);
            lat = (sz == 2'd2) ? 1 : (hit ? 1 : 3);
        end
        if (!exp_err) begin
            byp_v = 1;
            byp_w = a[31:2];
        end
        req_write = w; req_size = sz; req_signed = sg; req_address = a; req_wdata = wd;
        req_valid = 1'b1;
        pend = 1;
        due  = cycle + 1 + lat;
        @(negedge clock); #1;
        req_valid = 1'b0;
        req_address = 32'hFFFF_FFFF;
        req_wdata = 32'hA5A5_A5A5;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
    } op_t;

    op_t b2b [8];

    initial begin
        int n;
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_address = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_we", {31'b0, mem_write_enable}, 32'd0);
        reset = 1'b1;
        @(negedge clock); #1;

        // Word store, then lane loads
        issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        chk("ws_we", {31'b0, mem_write_enable}, 32'd1);
        chk("ws_addr", {2'b0, mem_address}, 32'd4);
        chk("ws_data", mem_write_input, 32'hDEADBEEF);
        wait_done();
        chk("ws_err", {31'b0, resp_error}, 32'd0);
        issue(0, 2'd0, 1, 32'h13, 32'h0); wait_done();
        chk("lb_signed", resp_rdata, 32'hFFFFFFDE);
        issue(0, 2'd0, 0, 32'h13, 32'h0); wait_done();
        chk("lb_unsigned", resp_rdata, 32'h000000DE);
        issue(0, 2'd1, 1, 32'h12, 32'h0); wait_done();
        chk("lh_signed", resp_rdata, 32'hFFFFDEAD);

        // Sub-word store by read-modify-write
        issue(1, 2'd0, 0, 32'h11, 32'h55); wait_done();
        issue(0, 2'd2, 0, 32'h10, 32'h0); wait_done();
        chk("rmw_word", resp_rdata, 32'hDEAD55EF);
        issue(1, 2'd1, 0, 32'h16, 32'hFFFFABCD); wait_done();
        issue(0, 2'd2, 0, 32'h14, 32'h0); wait_done();
        chk("sh_word", resp_rdata, 32'hABCD0000);

        // Error cases: one cycle, no memory traffic
        issue(0, 2'd1, 0, 32'h11, 32'h0);
        chk("err_half_lat", {31'b0, resp_valid}, 32'd1);
        chk("err_half", {31'b0, resp_error}, 32'd1);
        issue(0, 2'd2, 0, 32'h12, 32'h0);
        chk("err_word", {31'b0, resp_error}, 32'd1);
        issue(1, 2'd3, 0, 32'h10, 32'h0);
        chk("err_size", {31'b0, resp_error}, 32'd1);
        issue(0, 2'd2, 0, 32'h1000, 32'h0);
        chk("err_range", {31'b0, resp_error}, 32'd1);
        issue(1, 2'd1, 0, 32'h1001, 32'h1234);
        chk("err_rdata", resp_rdata, 32'd0);

        // Top valid word
        issue(1, 2'd2, 0, 32'hFFC, 32'h12345678); wait_done();
        issue(0, 2'd1, 0, 32'hFFE, 32'h0); wait_done();
        chk("top_half", resp_rdata, 32'h00001234);
        issue(0, 2'd0, 1, 32'hFFC, 32'h0); wait_done();
        chk("top_byte", resp_rdata, 32'h00000078);

        // Back-to-back stream
        b2b[0] = '{1, 2'd2, 0, 32'h20, 32'h80FF7F01};
        b2b[1] = '{0, 2'd0, 1, 32'h20, 32'h0};
        b2b[2] = '{0, 2'd0, 1, 32'h21, 32'h0};
        b2b[3] = '{0, 2'd0, 1, 32'h22, 32'h0};
        b2b[4] = '{0, 2'd0, 1, 32'h23, 32'h0};
        b2b[5] = '{0, 2'd1, 0, 32'h22, 32'h0};
        b2b[6] = '{1, 2'd1, 0, 32'h20, 32'h1234};
        b2b[7] = '{0, 2'd2, 0, 32'h20, 32'h0};
        for (int i = 0; i < 8; i++) issue(b2b[i].w, b2b[i].sz, b2b[i].sg, b2b[i].a, b2b[i].wd);
        wait_done();
        chk("b2b_last", resp_rdata, 32'h80FF1234);

        // Reset while a sub-word store is in READ
        issue(1, 2'd2, 0, 32'h30, 32'hCAFEF00D); wait_done();
        issue(0, 2'd2, 0, 32'h14, 32'h0); wait_done();
        issue(1, 2'd0, 0, 32'h31, 32'h99);
        reset = 1'b0;
        @(negedge clock); #1;
        chk("rr_ready", {31'b0, req_ready}, 32'd1);
        chk("rr_valid", {31'b0, resp_valid}, 32'd0);
        chk("rr_error", {31'b0, resp_error}, 32'd0);
        chk("rr_rdata", resp_rdata, 32'd0);
        chk("rr_we", {31'b0, mem_write_enable}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        issue(0, 2'd2, 0, 32'h30, 32'h0); wait_done();
        chk("rr_nowrite", resp_rdata, 32'hCAFEF00D);

        // Repeated load of the same word
        issue(0, 2'd2, 0, 32'h10, 32'h0);
        issue(0, 2'd2, 0, 32'h10, 32'h0);
        n = 0;
        while (!resp_valid && n < 8) begin
            @(negedge clock); #1;
            n++;
        end
`ifdef MAU_LAST_WORD_BYPASS_EN
        chk("repeat_load_lat", 32'(n), 32'd0);
`else
        chk("repeat_load_lat", 32'(n), 32'd2);
`endif
        wait_done();
        chk("repeat_load_data", resp_rdata, 32'hDEAD55EF);
        issue(1, 2'd0, 0, 32'h12, 32'h77); wait_done();
        issue(0, 2'd2, 0, 32'h10, 32'h0); wait_done();
        chk("final_word", resp_rdata, 32'hDE7755EF);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
